// File: rtl/adder_vector_checker_if.sv
// adder_vector_checker_if: operand/result bus between the vector checker (master) and the adder under test (slave).
interface adder_vector_checker_if;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic        cin_out;
    logic [31:0] sum_in;
    logic        cout_in;

    modport master (output a_out, b_out, cin_out, input sum_in, cout_in);
    modport slave  (input a_out, b_out, cin_out, output sum_in, cout_in);
endinterface

// File: rtl/adder_vector_checker.sv
// adder_vector_checker: drives corner then LFSR vectors into a registered adder and checks latency-aligned results.
module adder_vector_checker #(
    parameter logic [31:0] SEED        = 32'hACE1_2345,
    parameter int          NUM_VECTORS = 1024,
    parameter int          LATENCY     = 2,
    parameter int          CNT_W       = 16,
    parameter int          ERR_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    adder_vector_checker_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CNT_W-1:0]       vec_count,
    output logic [ERR_W-1:0]       err_count,
    output logic [CNT_W-1:0]       first_fail_index,
    output logic [32:0]            first_fail_exp,
    output logic [32:0]            first_fail_got
);
    localparam logic [31:0] TAPS   = 32'h8020_0003;
    localparam logic [31:0] SEED_A = SEED == '0 ? 32'h1 : SEED;
    localparam logic [31:0] SEED_B = ~SEED == '0 ? 32'h1 : ~SEED;
    localparam int          DW     = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [31:0]      lfsr_a, lfsr_b, vec_a, vec_b;
    logic             vec_cin, corner, launch, miss;
    logic [32:0]      vec_exp, got;
    logic [CNT_W-1:0] idx;
    logic [DW-1:0]    drain_cnt;
    logic [LATENCY:0] pipe_v;
    logic [32:0]      pipe_exp [LATENCY+1];
    logic [CNT_W-1:0] pipe_idx [LATENCY+1];

    function automatic logic [31:0] step(input logic [31:0] s);
        return s[0] ? (s >> 1) ^ TAPS : s >> 1;
    endfunction

    // Indices 0..3 are the fixed carry-chain corners; later vectors come straight from the LFSRs.
    assign corner  = idx < CNT_W'(4);
    assign launch  = state == RUN;
    assign vec_a   = idx == '0 ? '0 : idx == CNT_W'(3) ? 32'h8000_0000 : corner ? '1 : lfsr_a;
    assign vec_b   = idx == CNT_W'(2) ? '1 : idx == CNT_W'(3) ? 32'h8000_0000 : corner ? '0 : lfsr_b;
    assign vec_cin = corner ? (idx == CNT_W'(1) || idx == CNT_W'(2)) : lfsr_a[0] ^ lfsr_b[31];
    assign vec_exp = {1'b0, vec_a} + {1'b0, vec_b} + 33'(vec_cin);
    assign got     = {bus.cout_in, bus.sum_in};
    assign miss    = pipe_v[LATENCY] && got != pipe_exp[LATENCY];
    assign pass    = done && err_count == '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            vec_count        <= '0;
            err_count        <= '0;
            first_fail_index <= '0;
            first_fail_exp   <= '0;
            first_fail_got   <= '0;
            bus.a_out        <= '0;
            bus.b_out        <= '0;
            bus.cin_out      <= 1'b0;
            lfsr_a           <= SEED_A;
            lfsr_b           <= SEED_B;
            idx              <= '0;
            drain_cnt        <= '0;
            pipe_v           <= '0;
            for (int i = 0; i <= LATENCY; i++) begin
                pipe_exp[i] <= '0;
                pipe_idx[i] <= '0;
            end
        end else begin
            for (int i = LATENCY; i > 0; i--) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_exp[i] <= pipe_exp[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
            pipe_v[0]   <= launch;
            pipe_exp[0] <= vec_exp;
            pipe_idx[0] <= idx;
            bus.a_out   <= launch ? vec_a : '0;
            bus.b_out   <= launch ? vec_b : '0;
            bus.cin_out <= launch && vec_cin;
            if (pipe_v[LATENCY]) begin
                vec_count <= vec_count + CNT_W'(1);
                if (miss) begin
                    err_count <= err_count == '1 ? err_count : err_count + ERR_W'(1);
                    if (err_count == '0) begin
                        first_fail_index <= pipe_idx[LATENCY];
                        first_fail_exp   <= pipe_exp[LATENCY];
                        first_fail_got   <= got;
                    end
                end
            end
            case (state)
                IDLE, DONE: if (start) begin
                    state            <= RUN;
                    busy             <= 1'b1;
                    done             <= 1'b0;
                    vec_count        <= '0;
                    err_count        <= '0;
                    first_fail_index <= '0;
                    first_fail_exp   <= '0;
                    first_fail_got   <= '0;
                    lfsr_a           <= SEED_A;
                    lfsr_b           <= SEED_B;
                    idx              <= '0;
                end
                RUN: begin
                    idx <= idx + CNT_W'(1);
                    if (!corner) begin
                        lfsr_a <= step(lfsr_a);
                        lfsr_b <= step(lfsr_b);
                    end
                    if (idx == CNT_W'(NUM_VECTORS - 1)) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: if (drain_cnt == DW'(LATENCY)) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    drain_cnt <= drain_cnt + DW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_vector_checker.sv
// tb_adder_vector_checker: directed checks of the vector checker against a two-stage reference adder with injectable faults.
module tb_adder_vector_checker;
    logic clk = 1'b0, reset = 1'b1, start1 = 1'b0, start2 = 1'b0;
    logic stuck31 = 1'b0, inv_cout = 1'b0;
    int   tests = 0, fails = 0, m;
    logic busy1, done1, pass1, busy2, done2, pass2;
    logic [15:0] vc1, ec1, ffi1, vc2, ffi2;
    logic [3:0]  ec2;
    logic [32:0] ffe1, ffg1, ffe2, ffg2;
    logic [32:0] s1a = '0, s2a = '0, s1b = '0, s2b = '0;
    logic [31:0] ea [5] = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hACE1_2345};
    logic [31:0] eb [5] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h531E_DCBA};
    logic        ec [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    adder_vector_checker_if bus1 ();
    adder_vector_checker_if bus2 ();

    adder_vector_checker #(.NUM_VECTORS(16)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .bus(bus1.master),
        .busy(busy1), .done(done1), .pass(pass1), .vec_count(vc1), .err_count(ec1),
        .first_fail_index(ffi1), .first_fail_exp(ffe1), .first_fail_got(ffg1));

    adder_vector_checker #(.NUM_VECTORS(20), .ERR_W(4)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .bus(bus2.master),
        .busy(busy2), .done(done2), .pass(pass2), .vec_count(vc2), .err_count(ec2),
        .first_fail_index(ffi2), .first_fail_exp(ffe2), .first_fail_got(ffg2));

    always @(posedge clk) begin
        s1a <= {1'b0, bus1.a_out} + {1'b0, bus1.b_out} + 33'(bus1.cin_out);
        s2a <= s1a;
        s1b <= {1'b0, bus2.a_out} + {1'b0, bus2.b_out} + 33'(bus2.cin_out);
        s2b <= s1b;
    end
    assign bus1.sum_in  = s2a[31:0] & ~{stuck31, 31'b0};
    assign bus1.cout_in = s2a[32];
    assign bus2.sum_in  = s2b[31:0];
    assign bus2.cout_in = s2b[32] ^ inv_cout;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_idle(input int which, output int n);
        n = 0;
        while ((which == 1 ? busy1 : busy2) && n < 500) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_corners(input string tag);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("%s_vec%0d", tag, k), {bus1.cin_out, bus1.a_out, bus1.b_out}, {ec[k], ea[k], eb[k]});
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_flags", {busy1, done1, pass1, busy2, done2, pass2}, 0);
        check("rst_counts", {vc1, ec1, ffi1}, 0);
        check("rst_bus", {bus1.cin_out, bus1.a_out, bus1.b_out}, 0);
        check("rst_capture", {ffe1, ffg1}, 0);
        reset = 1'b0;
        // Clean run: corners, first LFSR vector, busy length and final result.
        pulse(1);
        check("t1_busy_start", {busy1, done1}, 2'b10);
        check_corners("t2");
        wait_idle(1, m);
        check("t1_busy_cycles", 6 + m - 1, 19);
        check("t1_done", {busy1, done1, pass1}, 3'b011);
        check("t1_counts", {vc1, ec1}, {16'd16, 16'd0});
        // Asynchronous reset in the middle of a run, then a bit-exact replay.
        pulse(1);
        repeat (8) @(negedge clk);
        check("t4_mid_count", vc1, 5);
        #1 reset = 1'b1;
        #1 check("t4_async_flags", {busy1, done1, pass1}, 0);
        check("t4_async_state", {vc1, ec1, bus1.cin_out, bus1.a_out, bus1.b_out}, 0);
        @(negedge clk);
        reset = 1'b0;
        pulse(1);
        check_corners("t4");
        wait_idle(1, m);
        check("t4_final", {done1, pass1, vc1}, {2'b11, 16'd16});
        // Bit 31 stuck low, with a start pulse ignored mid-run.
        stuck31 = 1'b1;
        pulse(1);
        repeat (5) @(negedge clk);
        pulse(1);
        wait_idle(1, m);
        check("t3_no_timeout", m < 500, 1);
        check("t3_flags", {done1, pass1, ec1 != 0}, 3'b101);
        check("t5_vec_count", vc1, 16);
        check("t3_fail_index", ffi1, 2);
        check("t3_fail_exp", ffe1, 33'h1_FFFF_FFFF);
        check("t3_fail_got", ffg1, 33'h1_7FFF_FFFF);
        // Restart from DONE clears everything from the faulty run.
        stuck31 = 1'b0;
        pulse(1);
        check("t5_restart_flags", {busy1, done1, pass1}, 3'b100);
        check("t5_restart_counts", {vc1, ec1, ffi1}, 0);
        check("t5_restart_capture", {ffe1, ffg1}, 0);
        wait_idle(1, m);
        check("t5_rerun", {done1, pass1, vc1}, {2'b11, 16'd16});
        // Inverted carry-out on every vector saturates a 4-bit error counter.
        inv_cout = 1'b1;
        pulse(2);
        wait_idle(2, m);
        check("t6_flags", {done2, pass2}, 2'b10);
        check("t6_counts", {vc2, ec2}, {16'd20, 4'hF});
        check("t6_first", {ffi2, ffe2, ffg2}, {16'd0, 33'h0, 33'h1_0000_0000});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
